// File: rtl/exc_ctrl.sv
// exc_ctrl: MIPS exception sequencer with CP0 EPC/Cause/Status(/BadVAddr).
// Define EXC_BADVADDR_EN to implement the BadVAddr register at CP0 address 8.
module exc_ctrl #(
    parameter int          FLUSH_CYCLES = 2,
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_valid,
    input  logic [8:0]  except_in,
    input  logic [31:0] mem_pc,
    input  logic [31:0] mem_addr,
    input  logic [5:0]  hw_int,
    input  logic        cp0_we,
    input  logic [4:0]  cp0_addr,
    input  logic [31:0] cp0_wdata,
    output logic [31:0] cp0_rdata,
    output logic        flush,
    output logic        busy,
    output logic        redir_valid,
    output logic [31:0] redir_pc,
    input  logic        redir_ack
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FLUSH,
        S_REDIR
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] status_q;
    logic [31:0] epc_q;
    logic [31:0] tgt_q;
    logic [5:0]  ip_hw_q;
    logic [1:0]  ip_sw_q;
    logic [4:0]  code_q;
    logic [31:0] cause;
    logic [31:0] bad_rd;

    logic        idle;
    logic        int_pend;
    logic        exc_any;
    logic        take;
    logic        eret;
    logic        bad_hit;
    logic [4:0]  code;
    logic        wr_status;
    logic        wr_cause;
    logic        wr_epc;

    assign idle     = (state_q == S_IDLE);
    assign int_pend = (|(hw_int & status_q[15:10]))
                    & status_q[0] & ~status_q[1];
    assign exc_any  = |except_in[7:1];
    assign take     = idle & mem_valid & (int_pend | exc_any);
    assign eret     = idle & mem_valid & except_in[0]
                    & ~int_pend & ~exc_any;

    assign wr_status = cp0_we & (cp0_addr == 5'd12);
    assign wr_cause  = cp0_we & (cp0_addr == 5'd13);
    assign wr_epc    = cp0_we & (cp0_addr == 5'd14);

    // Several causes may be raised together; the first match wins.
    always_comb begin
        code    = 5'd0;
        bad_hit = 1'b0;
        priority case (1'b1)
            int_pend:     code = 5'd0;
            except_in[7]: begin
                code    = 5'd4;
                bad_hit = 1'b1;
            end
            except_in[6]: code = 5'd10;
            except_in[5]: code = 5'd12;
            except_in[4]: code = 5'd8;
            except_in[3]: code = 5'd9;
            except_in[2]: begin
                code    = 5'd4;
                bad_hit = 1'b1;
            end
            except_in[1]: begin
                code    = 5'd5;
                bad_hit = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        flush       = 1'b0;
        redir_valid = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (take || eret) begin
                    state_d = S_FLUSH;
                    cnt_d   = CNT_INIT;
                end
            end
            S_FLUSH: begin
                flush = 1'b1;
                if (cnt_q == 4'd0) state_d = S_REDIR;
                else               cnt_d   = cnt_q - 4'd1;
            end
            S_REDIR: begin
                redir_valid = 1'b1;
                if (redir_ack) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy     = ~idle;
    assign redir_pc = tgt_q;

    // Hardware updates take precedence over a same-cycle mtc0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status_q <= 32'h0000_0002;
            epc_q    <= 32'd0;
            tgt_q    <= 32'd0;
            ip_hw_q  <= 6'd0;
            ip_sw_q  <= 2'd0;
            code_q   <= 5'd0;
        end else begin
            ip_hw_q <= hw_int;
            if (take)           status_q[1] <= 1'b1;
            else if (eret)      status_q[1] <= 1'b0;
            else if (wr_status) status_q    <= cp0_wdata;
            if (take)        epc_q <= mem_pc;
            else if (wr_epc) epc_q <= cp0_wdata;
            if (take)          code_q  <= code;
            else if (wr_cause) ip_sw_q <= cp0_wdata[9:8];
            if (take)      tgt_q <= EXC_VECTOR;
            else if (eret) tgt_q <= epc_q;
        end
    end

    assign cause = {16'd0, ip_hw_q, ip_sw_q, 1'b0, code_q, 2'b00};

`ifdef EXC_BADVADDR_EN
    logic [31:0] bad_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)             bad_q <= 32'd0;
        else if (take & bad_hit) bad_q <= mem_addr;
    end

    assign bad_rd = bad_q;
`else
    logic unused_bad;

    assign bad_rd     = 32'd0;
    assign unused_bad = ^{mem_addr, bad_hit};
`endif

    logic unused_rsvd;
    assign unused_rsvd = except_in[8];

    always_comb begin
        cp0_rdata = 32'd0;
        case (cp0_addr)
            5'd8:    cp0_rdata = bad_rd;
            5'd12:   cp0_rdata = status_q;
            5'd13:   cp0_rdata = cause;
            5'd14:   cp0_rdata = epc_q;
            default: cp0_rdata = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_exc_ctrl.sv
// tb_exc_ctrl: directed bench for exc_ctrl with a cycle-count reference model
// checked on every falling edge, plus literal expectations per scenario.
module tb_exc_ctrl;

    localparam int          F   = 2;
    localparam logic [31:0] VEC = 32'hBFC00380;
`ifdef EXC_BADVADDR_EN
    localparam bit BAD_EN = 1'b1;
`else
    localparam bit BAD_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_valid = 1'b0;
    logic [8:0]  except_in = '0;
    logic [31:0] mem_pc = '0;
    logic [31:0] mem_addr = '0;
    logic [5:0]  hw_int = '0;
    logic        cp0_we = 1'b0;
    logic [4:0]  cp0_addr = 5'd12;
    logic [31:0] cp0_wdata = '0;
    logic [31:0] cp0_rdata;
    logic        flush;
    logic        busy;
    logic        redir_valid;
    logic [31:0] redir_pc;
    logic        redir_ack = 1'b0;

    exc_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem_valid  (mem_valid),
        .except_in  (except_in),
        .mem_pc     (mem_pc),
        .mem_addr   (mem_addr),
        .hw_int     (hw_int),
        .cp0_we     (cp0_we),
        .cp0_addr   (cp0_addr),
        .cp0_wdata  (cp0_wdata),
        .cp0_rdata  (cp0_rdata),
        .flush      (flush),
        .busy       (busy),
        .redir_valid(redir_valid),
        .redir_pc   (redir_pc),
        .redir_ack  (redir_ack)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    bit run = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Reference model: k counts cycles since the accepting edge (-1 = idle).
    logic [31:0] m_status = 32'h2;
    logic [31:0] m_epc = '0;
    logic [31:0] m_bad = '0;
    logic [31:0] m_tgt = '0;
    logic [5:0]  m_hw = '0;
    logic [1:0]  m_sw = '0;
    logic [4:0]  m_code = '0;
    int          k = -1;

    int cbit[7]  = '{7, 6, 5, 4, 3, 2, 1};
    int ccode[7] = '{4, 10, 12, 8, 9, 4, 5};
    bit cbad[7]  = '{1, 0, 0, 0, 0, 1, 1};

    always @(posedge clk or negedge rst_n) begin : model
        bit found, pend, st_hw, hw_upd, isbad;
        int c;
        if (!rst_n) begin
            m_status = 32'h2;
            m_epc = 0;
            m_bad = 0;
            m_tgt = 0;
            m_hw = 0;
            m_sw = 0;
            m_code = 0;
            k = -1;
        end else begin
            st_hw = 0;
            hw_upd = 0;
            if (k < 0) begin
                if (mem_valid) begin
                    pend = ((hw_int & m_status[15:10]) != 0)
                           && m_status[0] && !m_status[1];
                    found = pend;
                    c = 0;
                    isbad = 0;
                    for (int i = 0; i < 7 && !found; i++)
                        if (except_in[cbit[i]]) begin
                            found = 1;
                            c = ccode[i];
                            isbad = cbad[i];
                        end
                    if (found) begin
                        m_epc = mem_pc;
                        m_status[1] = 1'b1;
                        m_code = 5'(c);
                        if (isbad) m_bad = mem_addr;
                        m_tgt = VEC;
                        k = 1;
                        st_hw = 1;
                        hw_upd = 1;
                    end else if (except_in[0]) begin
                        m_status[1] = 1'b0;
                        m_tgt = m_epc;
                        k = 1;
                        st_hw = 1;
                    end
                end
            end else if (k > F && redir_ack) begin
                k = -1;
            end else begin
                k++;
            end
            if (cp0_we) begin
                case (cp0_addr)
                    5'd12: if (!st_hw) m_status = cp0_wdata;
                    5'd13: if (!hw_upd) m_sw = cp0_wdata[9:8];
                    5'd14: if (!hw_upd) m_epc = cp0_wdata;
                    default: ;
                endcase
            end
            m_hw = hw_int;
        end
    end

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        case (a)
            5'd8:    return BAD_EN ? m_bad : 32'd0;
            5'd12:   return m_status;
            5'd13:   return {16'd0, m_hw, m_sw, 1'b0, m_code, 2'b00};
            5'd14:   return m_epc;
            default: return 32'd0;
        endcase
    endfunction

    always @(negedge clk) begin
        if (run) begin
            chk("flush", 32'(flush), 32'(k >= 1 && k <= F));
            chk("busy", 32'(busy), 32'(k >= 1));
            chk("redir_valid", 32'(redir_valid), 32'(k > F));
            chk("redir_pc", redir_pc, m_tgt);
            chk("cp0_rdata", cp0_rdata, exp_rd(cp0_addr));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        cp0_we = 1'b1;
        cp0_addr = a;
        cp0_wdata = d;
        cyc();
        cp0_we = 1'b0;
    endtask

    task automatic fire(input logic [8:0] e, input logic [31:0] pc,
                        input logic [31:0] ad);
        mem_valid = 1'b1;
        except_in = e;
        mem_pc = pc;
        mem_addr = ad;
        cyc();
        mem_valid = 1'b0;
        except_in = '0;
    endtask

    task automatic wait_redir(output int nf);
        nf = 0;
        for (int i = 0; i < 20 && !redir_valid; i++) begin
            if (flush) nf++;
            cyc();
        end
        chk("redir_wait", 32'(redir_valid), 32'd1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20 && busy; i++) cyc();
        chk("idle_wait", 32'(busy), 32'd0);
    endtask

    task automatic ack_now();
        redir_ack = 1'b1;
        cyc();
        redir_ack = 1'b0;
    endtask

    task automatic rd(input string nm, input logic [4:0] a,
                      input logic [31:0] exp);
        cp0_addr = a;
        #1;
        chk(nm, cp0_rdata, exp);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int nf;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_flush", 32'(flush), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rv", 32'(redir_valid), 32'd0);
        chk("rst_pc", redir_pc, 32'd0);
        rd("rst_status", 5'd12, 32'h2);
        rd("rst_epc", 5'd14, 32'h0);
        rst_n = 1'b1;
        run = 1'b1;
        cyc();

        fire(9'h020, 32'h0040_0010, 32'h0);
        wait_redir(nf);
        chk("ov_flush_cycles", nf, F);
        chk("ov_redir_pc", redir_pc, VEC);
        repeat (2) cyc();
        ack_now();
        chk("ov_idle", 32'(busy), 32'd0);
        rd("ov_epc", 5'd14, 32'h0040_0010);
        rd("ov_cause", 5'd13, 32'h30);
        rd("ov_status", 5'd12, 32'h2);

        redir_ack = 1'b1;
        mem_valid = 1'b1;
        except_in = 9'h0A0;
        mem_pc = 32'h0040_0020;
        mem_addr = 32'h0040_0003;
        cyc();
        except_in = 9'h010;
        mem_pc = 32'h0BAD_0000;
        cyc();
        mem_valid = 1'b0;
        except_in = '0;
        wait_idle();
        redir_ack = 1'b0;
        rd("sim_epc", 5'd14, 32'h0040_0020);
        rd("sim_cause", 5'd13, 32'h10);
        rd("sim_bad", 5'd8, BAD_EN ? 32'h0040_0003 : 32'h0);

        mtc0(5'd14, 32'h0040_0100);
        fire(9'h001, 32'h0040_0044, 32'h0);
        wait_redir(nf);
        chk("eret_flush_cycles", nf, F);
        repeat (5) cyc();
        chk("eret_rv_held", 32'(redir_valid), 32'd1);
        chk("eret_pc", redir_pc, 32'h0040_0100);
        ack_now();
        rd("eret_status", 5'd12, 32'h0);

        mtc0(5'd12, 32'h0000_0401);
        hw_int = 6'b000001;
        fire(9'h000, 32'h0040_0200, 32'h0);
        wait_redir(nf);
        chk("int_pc", redir_pc, VEC);
        ack_now();
        rd("int_cause", 5'd13, 32'h400);
        rd("int_epc", 5'd14, 32'h0040_0200);
        rd("int_status", 5'd12, 32'h403);

        mtc0(5'd12, 32'h0000_0400);
        mem_valid = 1'b1;
        repeat (3) begin
            cyc();
            chk("mask_busy", 32'(busy), 32'd0);
        end
        mem_valid = 1'b0;
        hw_int = '0;

        mtc0(5'd13, 32'hFFFF_FFFF);
        rd("sw_cause", 5'd13, 32'h300);

        cp0_we = 1'b1;
        cp0_addr = 5'd14;
        cp0_wdata = 32'hDEAD_0000;
        fire(9'h040, 32'h0040_0300, 32'h0);
        cp0_we = 1'b0;
        wait_redir(nf);
        ack_now();
        rd("race_epc", 5'd14, 32'h0040_0300);
        rd("race_cause", 5'd13, 32'h328);

        fire(9'h010, 32'h0040_0400, 32'h0);
        wait_redir(nf);
        rst_n = 1'b0;
        #1;
        chk("mid_flush", 32'(flush), 32'd0);
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_rv", 32'(redir_valid), 32'd0);
        chk("mid_pc", redir_pc, 32'd0);
        rd("mid_status", 5'd12, 32'h2);
        rd("mid_epc", 5'd14, 32'h0);
        cyc();
        rst_n = 1'b1;
        cyc();
        fire(9'h008, 32'h0040_0500, 32'h0);
        wait_redir(nf);
        chk("post_flush_cycles", nf, F);
        ack_now();
        rd("post_epc", 5'd14, 32'h0040_0500);
        rd("post_cause", 5'd13, 32'h24);
        cyc();

        run = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
